// File: rtl/ref_bram_pkg.sv
// Shared definitions for the reference BRAM loader.
//   state_e : loader FSM encoding (StIdle, StLoad, StDrain, StDone)
//   REAL_LSB / IMAG_LSB / FIELD_W : slice positions of the complex word {imag, real}
//   sat_neg : saturating two's-complement negate of one Q1.31 field
package ref_bram_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned REAL_LSB = 0;
  localparam int unsigned IMAG_LSB = 32;
  localparam int unsigned FIELD_W  = 32;

  // -(-1.0) is not representable in Q1.31; clip it to the largest positive value.
  function automatic logic [FIELD_W-1:0] sat_neg(input logic [FIELD_W-1:0] x);
    logic [FIELD_W-1:0] min_val;
    min_val = {1'b1, {(FIELD_W-1){1'b0}}};
    if (x == min_val) begin
      sat_neg = ~min_val;
    end else begin
      sat_neg = {FIELD_W{1'b0}} - x;
    end
  endfunction

endpackage

// File: rtl/ref_bram_loader_if.sv
// AXI4-Stream bundle carrying the reference sequence into the loader.
//   TDATA  : {imag[63:32], real[31:0]} reference word
//   TSTRB  : byte qualifier (carried, not used by the loader)
//   TLAST  : last word of the sequence
//   TVALID : source has a word
//   TREADY : sink accepts the word
// Modports: master (stream source), slave (loader side).
interface ref_bram_loader_if #(
  parameter int unsigned DATA_W = 64
);

  logic [DATA_W-1:0]   TDATA;
  logic [DATA_W/8-1:0] TSTRB;
  logic                TLAST;
  logic                TVALID;
  logic                TREADY;

  modport master (
    output TDATA,
    output TSTRB,
    output TLAST,
    output TVALID,
    input  TREADY
  );

  modport slave (
    input  TDATA,
    input  TSTRB,
    input  TLAST,
    input  TVALID,
    output TREADY
  );

endinterface

// File: rtl/ref_bram_wr_stage.sv
// One-cycle registered BRAM write stage of the reference loader.
// Optional build macro: REF_CONJ_ON_LOAD_EN stores the complex conjugate {sat(-imag), real}
// instead of the raw stream word.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en             : accepted beat that must be written this cycle
//   wr_addr, wr_data  : address and raw stream word of that beat
//   BRAM_ADDR/DIN/EN/WE : registered BRAM write port, valid the cycle after the beat
module ref_bram_wr_stage
  import ref_bram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] BRAM_ADDR,
  output logic [DATA_W-1:0] BRAM_DIN,
  output logic              BRAM_EN,
  output logic              BRAM_WE
);

  logic [DATA_W-1:0] din_proc;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic              we_q;

  always_comb begin
`ifdef REF_CONJ_ON_LOAD_EN
    din_proc = {sat_neg(wr_data[IMAG_LSB +: FIELD_W]), wr_data[REAL_LSB +: FIELD_W]};
`else
    din_proc = wr_data;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      we_q <= wr_en;
      if (wr_en) begin
        addr_q <= wr_addr;
        din_q  <= din_proc;
      end
    end
  end

  assign BRAM_ADDR = addr_q;
  assign BRAM_DIN  = din_q;
  assign BRAM_EN   = we_q;
  assign BRAM_WE   = we_q;

endmodule

// File: rtl/ref_bram_loader.sv
// AXI4-Stream sink that loads the matched-filter reference sequence into the reference BRAM.
// Software pulses ARM with LOAD_LEN; words land at addresses 0..LOAD_LEN-1, then LOAD_DONE is
// raised with ERR_SHORT / ERR_LONG reporting a TLAST position mismatch.
// Optional build macro: REF_CONJ_ON_LOAD_EN (store conjugated words, see ref_bram_wr_stage).
// Ports:
//   S_AXIS_ACLK, S_AXIS_ARESET : clock, asynchronous active-high reset
//   ARM, LOAD_LEN              : load start pulse and word count (clamped to BRAM depth)
//   s_axis                     : stream input (slave modport)
//   BRAM_ADDR/DIN/EN/WE        : BRAM write port
//   LOAD_BUSY, LOAD_DONE       : status
//   ERR_SHORT, ERR_LONG        : TLAST early / missing on the final word
module ref_bram_loader
  import ref_bram_pkg::*;
#(
  parameter int unsigned BRAM_DEPTH_BITS      = 10,
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 64
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESET,
  input  logic                            ARM,
  input  logic [BRAM_DEPTH_BITS:0]        LOAD_LEN,
  ref_bram_loader_if.slave                s_axis,
  output logic [BRAM_DEPTH_BITS-1:0]      BRAM_ADDR,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] BRAM_DIN,
  output logic                            BRAM_EN,
  output logic                            BRAM_WE,
  output logic                            LOAD_BUSY,
  output logic                            LOAD_DONE,
  output logic                            ERR_SHORT,
  output logic                            ERR_LONG
);

  localparam int unsigned LenW = BRAM_DEPTH_BITS + 1;
  localparam logic [LenW-1:0] FullLen = {1'b1, {BRAM_DEPTH_BITS{1'b0}}};
  localparam logic [LenW-1:0] LenOne  = {{BRAM_DEPTH_BITS{1'b0}}, 1'b1};
  localparam logic [BRAM_DEPTH_BITS-1:0] CntOne = {{(BRAM_DEPTH_BITS-1){1'b0}}, 1'b1};

  state_e                     state_q, state_d;
  logic [BRAM_DEPTH_BITS-1:0] cnt_q, cnt_d;
  logic [LenW-1:0]            len_q, len_d;
  logic                       err_short_q, err_short_d;
  logic                       err_long_q, err_long_d;
  logic                       tready_q, tready_d;

  logic            beat;
  logic            arm_ok;
  logic            at_last;
  logic            wr_en;
  logic [LenW-1:0] len_clamped;
  logic            unused_tstrb;

  assign unused_tstrb = ^s_axis.TSTRB;

  assign beat        = s_axis.TVALID & tready_q;
  assign arm_ok      = ARM & (LOAD_LEN != '0);
  assign len_clamped = (LOAD_LEN > FullLen) ? FullLen : LOAD_LEN;
  // len_q >= 1 whenever this is consulted, so len_q - 1 never underflows.
  assign at_last     = ({1'b0, cnt_q} == (len_q - LenOne));

  // State register.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      tready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      tready_q    <= tready_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (arm_ok) begin
          state_d     = StLoad;
          cnt_d       = '0;
          len_d       = len_clamped;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
        end
      end
      StLoad: begin
        if (beat) begin
          if (at_last) begin
            // Counter holds at len-1 so the address never wraps.
            if (s_axis.TLAST) begin
              state_d = StDone;
            end else begin
              err_long_d = 1'b1;
              state_d    = StDrain;
            end
          end else begin
            cnt_d = cnt_q + CntOne;
            if (s_axis.TLAST) begin
              err_short_d = 1'b1;
              state_d     = StDone;
            end
          end
        end
      end
      StDrain: begin
        if (beat && s_axis.TLAST) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs. TREADY is registered from the next state so it tracks the state register exactly.
  always_comb begin
    tready_d  = (state_d == StLoad) || (state_d == StDrain);
    wr_en     = beat && (state_q == StLoad);
    LOAD_BUSY = (state_q == StLoad) || (state_q == StDrain);
    LOAD_DONE = (state_q == StDone);
  end

  assign s_axis.TREADY = tready_q;
  assign ERR_SHORT     = err_short_q;
  assign ERR_LONG      = err_long_q;

  ref_bram_wr_stage #(
    .ADDR_W (BRAM_DEPTH_BITS),
    .DATA_W (C_S_AXIS_TDATA_WIDTH)
  ) u_wr_stage (
    .clk       (S_AXIS_ACLK),
    .rst       (S_AXIS_ARESET),
    .wr_en     (wr_en),
    .wr_addr   (cnt_q),
    .wr_data   (s_axis.TDATA),
    .BRAM_ADDR (BRAM_ADDR),
    .BRAM_DIN  (BRAM_DIN),
    .BRAM_EN   (BRAM_EN),
    .BRAM_WE   (BRAM_WE)
  );

endmodule

// File: tb/tb_ref_bram_loader.sv
// Self-checking bench for ref_bram_loader: vector table of load scenarios plus directed
// sequences (ARM filtering, conjugate words, reset mid-load). Expected BRAM writes are queued
// when a beat is driven and popped when the DUT presents a write.
module tb_ref_bram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARM;
  logic [10:0] LOAD_LEN;
  logic [9:0]  BRAM_ADDR;
  logic [63:0] BRAM_DIN;
  logic        BRAM_EN, BRAM_WE, LOAD_BUSY, LOAD_DONE, ERR_SHORT, ERR_LONG;

  always #5 clk = ~clk;

  ref_bram_loader_if #(.DATA_W(64)) axis ();

  ref_bram_loader #(
    .BRAM_DEPTH_BITS      (10),
    .C_S_AXIS_TDATA_WIDTH (64)
  ) dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESET (rst),
    .ARM           (ARM),
    .LOAD_LEN      (LOAD_LEN),
    .s_axis        (axis),
    .BRAM_ADDR     (BRAM_ADDR),
    .BRAM_DIN      (BRAM_DIN),
    .BRAM_EN       (BRAM_EN),
    .BRAM_WE       (BRAM_WE),
    .LOAD_BUSY     (LOAD_BUSY),
    .LOAD_DONE     (LOAD_DONE),
    .ERR_SHORT     (ERR_SHORT),
    .ERR_LONG      (ERR_LONG)
  );

  typedef struct {
    int          cyc;
    logic [9:0]  addr;
    logic [63:0] data;
  } wr_exp_t;

  typedef struct {
    int len;
    int nbeats;
    int last_idx;
    int nwrite;
    bit e_short;
    bit e_long;
  } vec_t;

  wr_exp_t     sb[$];
  wr_exp_t     got;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          writes_seen = 0;
  logic [63:0] dat  [0:1023];
  logic [63:0] xdat [0:1023];
  vec_t        vecs [0:6];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model of the stored word.
  function automatic logic [63:0] exp_word(input logic [63:0] d);
`ifdef REF_CONJ_ON_LOAD_EN
    logic [31:0] im;
    im = d[63:32];
    if (im == 32'h8000_0000) return {32'h7fff_ffff, d[31:0]};
    return {32'd0 - im, d[31:0]};
`else
    return d;
`endif
  endfunction

  // Write monitor / scoreboard pop.
  always @(negedge clk) begin
    if (!rst && BRAM_WE) begin
      writes_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0d din=%h required no write", BRAM_ADDR,
                 BRAM_DIN);
      end else begin
        got = sb.pop_front();
        if (got.cyc != cyc || got.addr != BRAM_ADDR || got.data != BRAM_DIN || !BRAM_EN) begin
          errors++;
          $display("FAIL bram_write actual cyc=%0d addr=%0d din=%h en=%0b required cyc=%0d addr=%0d din=%h en=1",
                   cyc, BRAM_ADDR, BRAM_DIN, BRAM_EN, got.cyc, got.addr, got.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 1024; i++) begin
      dat[i]  = {$urandom, $urandom};
      xdat[i] = exp_word(dat[i]);
    end
  endtask

  // Called on a negedge; leaves ARM low on the following negedge.
  task automatic arm(input logic [10:0] len);
    ARM = 1'b1;
    LOAD_LEN = len;
    @(negedge clk);
    ARM = 1'b0;
  endtask

  task automatic run_beats(input int first, input int n, input int last_idx, input int nwrite);
    for (int i = first; i < first + n; i++) begin
      int w = 0;
      axis.TVALID = 1'b1;
      axis.TDATA  = dat[i];
      axis.TSTRB  = 8'($urandom);
      axis.TLAST  = (i == last_idx);
      while (!axis.TREADY && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!axis.TREADY) begin
        checks++;
        errors++;
        $display("FAIL tready_timeout beat=%0d actual=0 required=1", i);
        break;
      end
      if (i < nwrite) sb.push_back('{cyc + 1, i[9:0], xdat[i]});
      @(negedge clk);
    end
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
  endtask

  task automatic check_end(input string tag, input bit e_short, input bit e_long,
                           input int nwrite);
    @(negedge clk);
    chk({tag, "_done"}, LOAD_DONE, 1);
    chk({tag, "_busy"}, LOAD_BUSY, 0);
    chk({tag, "_tready"}, axis.TREADY, 0);
    chk({tag, "_err_short"}, ERR_SHORT, e_short);
    chk({tag, "_err_long"}, ERR_LONG, e_long);
    chk({tag, "_pending"}, sb.size(), 0);
    chk({tag, "_nwrites"}, writes_seen, nwrite);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_tready"}, axis.TREADY, 0);
    chk({tag, "_bram"}, {BRAM_ADDR, BRAM_EN, BRAM_WE}, 0);
    chk({tag, "_din"}, BRAM_DIN, 0);
    chk({tag, "_status"}, {LOAD_BUSY, LOAD_DONE, ERR_SHORT, ERR_LONG}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4,    4,    3,    4,    1'b0, 1'b0};
    vecs[1] = '{4,    3,    2,    3,    1'b1, 1'b0};
    vecs[2] = '{2,    5,    4,    2,    1'b0, 1'b1};
    vecs[3] = '{1024, 1024, 1023, 1024, 1'b0, 1'b0};
    vecs[4] = '{2000, 1024, 1023, 1024, 1'b0, 1'b0};
    vecs[5] = '{1,    1,    0,    1,    1'b0, 1'b0};
    vecs[6] = '{5,    1,    0,    1,    1'b1, 1'b0};

    rst = 1'b1;
    ARM = 1'b0;
    LOAD_LEN = '0;
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
    axis.TDATA  = '0;
    axis.TSTRB  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int v = 0; v < 7; v++) begin
      fill_random();
      writes_seen = 0;
      arm(vecs[v].len[10:0]);
      chk($sformatf("vec%0d_busy", v), LOAD_BUSY, 1);
      run_beats(0, vecs[v].nbeats, vecs[v].last_idx, vecs[v].nwrite);
      check_end($sformatf("vec%0d", v), vecs[v].e_short, vecs[v].e_long, vecs[v].nwrite);
    end

    // ARM with zero length in DONE is ignored: done and error flags stay put.
    arm(11'd0);
    @(negedge clk);
    chk("arm0_done", LOAD_DONE, 1);
    chk("arm0_err_short", ERR_SHORT, 1);
    chk("arm0_tready", axis.TREADY, 0);

    // ARM during LOAD is ignored: load completes at the original length and addresses.
    fill_random();
    writes_seen = 0;
    arm(11'd4);
    run_beats(0, 2, -1, 4);
    arm(11'd2);
    run_beats(2, 2, 3, 4);
    check_end("arm_busy", 1'b0, 1'b0, 4);

    // Conjugate handling of boundary words.
    dat[0] = 64'h8000_0000_0000_0005;
    dat[1] = 64'h0000_0003_0000_0007;
`ifdef REF_CONJ_ON_LOAD_EN
    xdat[0] = 64'h7fff_ffff_0000_0005;
    xdat[1] = 64'hffff_fffd_0000_0007;
`else
    xdat[0] = 64'h8000_0000_0000_0005;
    xdat[1] = 64'h0000_0003_0000_0007;
`endif
    writes_seen = 0;
    arm(11'd2);
    run_beats(0, 2, 1, 2);
    check_end("conj", 1'b0, 1'b0, 2);

    // Reset after 10 of 16 beats, then a fresh load restarts at address 0.
    fill_random();
    writes_seen = 0;
    arm(11'd16);
    axis.TVALID = 1'b0;
    run_beats(0, 10, -1, 10);
    axis.TVALID = 1'b1;
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    axis.TVALID = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_writes", writes_seen, 10);
    chk("midreset_pending", sb.size(), 0);
    @(negedge clk);
    fill_random();
    writes_seen = 0;
    arm(11'd16);
    run_beats(0, 16, 15, 16);
    check_end("rearm", 1'b0, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
